// File: rtl/dtlb_pkg.sv
// Shared definitions for the data-TLB: PTE layout, walker state encoding and
// the PPN width derivation used by both the CAM and the walker.
package dtlb_pkg;

    localparam int PTE_VALID = 15;
    localparam int PTE_WR    = 14;

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        FAULT
    } state_t;

    function automatic int ppn_width(input int paddr_width, input int page_offset);
        return paddr_width - page_offset;
    endfunction

endpackage

// File: rtl/dtlb_cam.sv
// Fully-associative translation store with two lookup ports, one refill port,
// flush, and victim selection (first invalid entry, else round-robin pointer).
module dtlb_cam
    import dtlb_pkg::*;
#(
    parameter int VPN_W       = 9,
    parameter int PPN_W       = 9,
    parameter int NUM_ENTRIES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [VPN_W-1:0] lookup_vpn0,
    input  logic [VPN_W-1:0] lookup_vpn1,
    output logic             match0,
    output logic             match1,
    output logic [PPN_W-1:0] ppn0,
    output logic [PPN_W-1:0] ppn1,
    output logic             wr0,
    output logic             wr1,
    input  logic             write_en,
    input  logic [VPN_W-1:0] write_vpn,
    input  logic [PPN_W-1:0] write_ppn,
    input  logic             write_wr
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);

    logic [NUM_ENTRIES-1:0] valid;
    logic [VPN_W-1:0]       vpn_tab [NUM_ENTRIES];
    logic [PPN_W-1:0]       ppn_tab [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] wr_tab;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       victim;
    logic                   victim_from_ptr;

    always_comb begin
        match0 = 1'b0;
        match1 = 1'b0;
        ppn0   = '0;
        ppn1   = '0;
        wr0    = 1'b0;
        wr1    = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (valid[i] && vpn_tab[i] == lookup_vpn0) begin
                match0 = 1'b1;
                ppn0   = ppn_tab[i];
                wr0    = wr_tab[i];
            end
            if (valid[i] && vpn_tab[i] == lookup_vpn1) begin
                match1 = 1'b1;
                ppn1   = ppn_tab[i];
                wr1    = wr_tab[i];
            end
        end
    end

    // Descending scan so the lowest-index invalid entry is the one that sticks.
    always_comb begin
        victim          = rr_ptr;
        victim_from_ptr = 1'b1;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                victim          = IDX_W'(i);
                victim_from_ptr = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid  <= '0;
            rr_ptr <= '0;
        end else if (write_en) begin
            valid[victim] <= 1'b1;
            if (victim_from_ptr)
                rr_ptr <= rr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (write_en && !flush && !reset) begin
            vpn_tab[victim] <= write_vpn;
            ppn_tab[victim] <= write_ppn;
            wr_tab[victim]  <= write_wr;
        end
    end

endmodule

// File: rtl/dtlb_walk_unit.sv
// Data-TLB for the memory stage: same-cycle translation of both bytes of an
// access, page-table walk on miss through the arbiter, and permission faults.
module dtlb_walk_unit
    import dtlb_pkg::*;
#(
    parameter int          VADDR_WIDTH = 16,
    parameter int          PADDR_WIDTH = 16,
    parameter int          PAGE_OFFSET = 7,
    parameter int          NUM_ENTRIES = 8,
    parameter logic [15:0] PT_BASE     = 16'hF000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic [VADDR_WIDTH-1:0] req_vaddr,
    input  logic                   req_word,
    input  logic                   req_we,
    input  logic                   flush,
    output logic                   stall,
    output logic                   hit,
    output logic [PADDR_WIDTH-1:0] paddr0,
    output logic [PADDR_WIDTH-1:0] paddr1,
    output logic                   fault,
    output logic [VADDR_WIDTH-1:0] fault_vaddr,
    output logic                   pet_arb,
    output logic [15:0]            addr_arb,
    input  logic                   ready_arb,
    input  logic [15:0]            rdata_arb
);

    localparam int PPN_W = ppn_width(PADDR_WIDTH, PAGE_OFFSET);
    localparam int VPN_W = VADDR_WIDTH - PAGE_OFFSET;

    state_t state, state_next;

    logic [VADDR_WIDTH-1:0] vaddr1;
    logic [VPN_W-1:0]       vpn0, vpn1, walk_vpn, walk_target, fault_vpn;
    logic                   match0, match1, wr0, wr1;
    logic [PPN_W-1:0]       ppn0, ppn1;
    logic                   walk_load, cam_we;
    logic                   unused_pte;

    assign vaddr1 = req_vaddr + 1'b1;
    assign vpn0   = req_vaddr[VADDR_WIDTH-1:PAGE_OFFSET];
    assign vpn1   = vaddr1[VADDR_WIDTH-1:PAGE_OFFSET];

    dtlb_cam #(
        .VPN_W       (VPN_W),
        .PPN_W       (PPN_W),
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_cam (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .lookup_vpn0 (vpn0),
        .lookup_vpn1 (vpn1),
        .match0      (match0),
        .match1      (match1),
        .ppn0        (ppn0),
        .ppn1        (ppn1),
        .wr0         (wr0),
        .wr1         (wr1),
        .write_en    (cam_we),
        .write_vpn   (walk_vpn),
        .write_ppn   (rdata_arb[PPN_W-1:0]),
        .write_wr    (rdata_arb[PTE_WR])
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            walk_vpn <= '0;
        end else begin
            state <= state_next;
            if (walk_load)
                walk_vpn <= walk_target;
        end
    end

    // Page 0 is resolved (miss or permission) before page 1 so faults stay precise.
    always_comb begin
        state_next  = state;
        stall       = 1'b0;
        hit         = 1'b0;
        fault       = 1'b0;
        fault_vpn   = '0;
        walk_load   = 1'b0;
        walk_target = vpn0;
        pet_arb     = 1'b0;
        cam_we      = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (!match0) begin
                        walk_load   = 1'b1;
                        walk_target = vpn0;
                    end else if (req_we && !wr0) begin
                        fault     = 1'b1;
                        fault_vpn = vpn0;
                    end else if (req_word && !match1) begin
                        walk_load   = 1'b1;
                        walk_target = vpn1;
                    end else if (req_word && req_we && !wr1) begin
                        fault     = 1'b1;
                        fault_vpn = vpn1;
                    end else begin
                        hit = 1'b1;
                    end
                    if (walk_load) begin
                        stall      = 1'b1;
                        state_next = WALK;
                    end
                end
            end
            WALK: begin
                stall   = 1'b1;
                pet_arb = 1'b1;
                if (ready_arb) begin
                    if (rdata_arb[PTE_VALID]) begin
                        cam_we     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = FAULT;
                    end
                end
            end
            FAULT: begin
                fault      = 1'b1;
                fault_vpn  = walk_vpn;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign fault_vaddr = {fault_vpn, {PAGE_OFFSET{1'b0}}};
    assign addr_arb    = pet_arb ? PT_BASE + 16'({walk_vpn, 1'b0}) : 16'h0000;
    assign paddr0      = match0 ? {ppn0, req_vaddr[PAGE_OFFSET-1:0]} : '0;
    assign paddr1      = match1 ? {ppn1, vaddr1[PAGE_OFFSET-1:0]} : '0;

    // PTE bits between the permission flags and the PPN are reserved.
    assign unused_pte = ^rdata_arb;

endmodule

// File: tb/tb_dtlb_walk_unit.sv
// Directed bench for dtlb_walk_unit: table of hit/permission vectors plus
// hand-written walk, crossing, replacement, flush and reset sequences.
module tb_dtlb_walk_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [15:0] req_vaddr = '0;
    logic        req_word = 1'b0;
    logic        req_we = 1'b0;
    logic        flush = 1'b0;
    logic        stall, hit, fault, pet_arb;
    logic [15:0] paddr0, paddr1, fault_vaddr, addr_arb;
    logic        ready_arb = 1'b0;
    logic [15:0] rdata_arb = '0;

    int checks = 0;
    int failures = 0;

    dtlb_walk_unit dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_vaddr   (req_vaddr),
        .req_word    (req_word),
        .req_we      (req_we),
        .flush       (flush),
        .stall       (stall),
        .hit         (hit),
        .paddr0      (paddr0),
        .paddr1      (paddr1),
        .fault       (fault),
        .fault_vaddr (fault_vaddr),
        .pet_arb     (pet_arb),
        .addr_arb    (addr_arb),
        .ready_arb   (ready_arb),
        .rdata_arb   (rdata_arb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [15:0] vaddr;
        logic        word;
        logic        we;
        logic        hit;
        logic        fault;
        logic [15:0] p0;
        logic [15:0] p1;
        logic [15:0] fva;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic req(input logic v, input logic [15:0] a, input logic w, input logic we);
        req_valid = v;
        req_vaddr = a;
        req_word  = w;
        req_we    = we;
    endtask

    // Entered just after the IDLE miss cycle was checked; returns #1 after the
    // negedge that follows the arbiter completion.
    task automatic do_walk(input string name, input logic [15:0] exp_addr,
                           input logic [15:0] pte, input int lat, input logic flush_at_ready);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk); #1;
            check({name, " pet_arb"}, pet_arb, 1'b1);
            check({name, " addr_arb"}, addr_arb, exp_addr);
            check({name, " stall"}, stall, 1'b1);
        end
        ready_arb = 1'b1;
        rdata_arb = pte;
        flush     = flush_at_ready;
        @(negedge clk);
        ready_arb = 1'b0;
        flush     = 1'b0;
        #1;
    endtask

    initial begin
        logic [15:0] va;
        logic [15:0] pte;

        vecs[0] = '{1'b1, 16'h0285, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0185, 16'h0186, 16'h0000};
        vecs[1] = '{1'b1, 16'h0285, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0185, 16'h0186, 16'h0280};
        vecs[2] = '{1'b1, 16'h00FF, 1'b1, 1'b0, 1'b1, 1'b0, 16'h027F, 16'h0480, 16'h0000};
        vecs[3] = '{1'b1, 16'h00FF, 1'b1, 1'b1, 1'b1, 1'b0, 16'h027F, 16'h0480, 16'h0000};
        vecs[4] = '{1'b1, 16'h0100, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0480, 16'h0481, 16'h0000};
        vecs[5] = '{1'b1, 16'h0080, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0200, 16'h0201, 16'h0000};
        vecs[6] = '{1'b1, 16'h02FE, 1'b1, 1'b0, 1'b1, 1'b0, 16'h01FE, 16'h01FF, 16'h0000};
        vecs[7] = '{1'b1, 16'h02FE, 1'b1, 1'b1, 1'b0, 1'b1, 16'h01FE, 16'h01FF, 16'h0280};
        vecs[8] = '{1'b0, 16'h0080, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0200, 16'h0201, 16'h0000};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst stall", stall, 1'b0);
        check("rst hit", hit, 1'b0);
        check("rst fault", fault, 1'b0);
        check("rst pet_arb", pet_arb, 1'b0);
        check("rst addr_arb", addr_arb, 16'h0000);
        check("rst paddr0", paddr0, 16'h0000);
        check("rst paddr1", paddr1, 16'h0000);
        check("rst fault_vaddr", fault_vaddr, 16'h0000);

        // Cold byte load, arbiter takes two cycles
        @(negedge clk); req(1, 16'h0285, 0, 0); #1;
        check("cold miss stall", stall, 1'b1);
        check("cold miss pet_arb", pet_arb, 1'b0);
        check("cold miss hit", hit, 1'b0);
        do_walk("cold", 16'hF00A, 16'h8003, 2, 1'b0);
        check("cold hit", hit, 1'b1);
        check("cold paddr0", paddr0, 16'h0185);
        check("cold stall", stall, 1'b0);

        // Store to read-only page
        @(negedge clk); req(1, 16'h0285, 0, 1); #1;
        check("ro fault", fault, 1'b1);
        check("ro fault_vaddr", fault_vaddr, 16'h0280);
        check("ro stall", stall, 1'b0);
        check("ro hit", hit, 1'b0);

        // Word load straddling pages 1 and 2
        @(negedge clk); req(1, 16'h00FF, 1, 0); #1;
        check("cross miss stall", stall, 1'b1);
        do_walk("cross0", 16'hF002, 16'hC004, 1, 1'b0);
        check("cross relookup stall", stall, 1'b1);
        check("cross relookup hit", hit, 1'b0);
        check("cross relookup pet_arb", pet_arb, 1'b0);
        do_walk("cross1", 16'hF004, 16'hC009, 1, 1'b0);
        check("cross hit", hit, 1'b1);
        check("cross paddr0", paddr0, 16'h027F);
        check("cross paddr1", paddr1, 16'h0480);

        for (int i = 0; i < 9; i++) begin
            @(negedge clk); req(vecs[i].valid, vecs[i].vaddr, vecs[i].word, vecs[i].we); #1;
            check($sformatf("vec%0d hit", i), hit, vecs[i].hit);
            check($sformatf("vec%0d fault", i), fault, vecs[i].fault);
            check($sformatf("vec%0d stall", i), stall, 1'b0);
            check($sformatf("vec%0d paddr0", i), paddr0, vecs[i].p0);
            check($sformatf("vec%0d paddr1", i), paddr1, vecs[i].p1);
            check($sformatf("vec%0d fault_vaddr", i), fault_vaddr, vecs[i].fva);
        end

        // Invalid PTE: fault pulse, nothing cached
        @(negedge clk); req(1, 16'h1000, 0, 0); #1;
        check("inv miss stall", stall, 1'b1);
        do_walk("inv", 16'hF040, 16'h0000, 1, 1'b0);
        check("inv fault", fault, 1'b1);
        check("inv fault_vaddr", fault_vaddr, 16'h1000);
        check("inv stall", stall, 1'b0);
        check("inv hit", hit, 1'b0);
        @(negedge clk); #1;
        check("inv not cached stall", stall, 1'b1);
        check("inv not cached hit", hit, 1'b0);
        do_walk("inv2", 16'hF040, 16'h0000, 1, 1'b0);
        @(negedge clk); req(0, 16'h0000, 0, 0); #1;
        check("inv fault drops", fault, 1'b0);

        // Flush on the refill edge suppresses the write
        @(negedge clk); req(1, 16'h1400, 0, 0); #1;
        check("fw miss stall", stall, 1'b1);
        do_walk("fw", 16'hF050, 16'hC011, 1, 1'b1);
        check("fw not written hit", hit, 1'b0);
        check("fw not written stall", stall, 1'b1);
        do_walk("fw2", 16'hF050, 16'hC011, 1, 1'b0);
        check("fw2 hit", hit, 1'b1);
        check("fw2 paddr0", paddr0, 16'h0880);

        // Fill nine pages into eight entries after a flush
        @(negedge clk); req(0, 16'h0000, 0, 0); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        for (int k = 0; k < 9; k++) begin
            va  = 16'(16 + k) << 7;
            pte = 16'hC000 | 16'(16 + k + 16'h40);
            @(negedge clk); req(1, va, 0, 0); #1;
            check($sformatf("fill%0d stall", k), stall, 1'b1);
            do_walk($sformatf("fill%0d", k), 16'hF000 + 16'((16 + k) * 2), pte, 1, 1'b0);
            check($sformatf("fill%0d hit", k), hit, 1'b1);
            check($sformatf("fill%0d paddr0", k), paddr0, 16'(16 + k + 16'h40) << 7);
        end
        @(negedge clk); req(1, 16'h0800, 0, 0); #1;
        check("evicted first stall", stall, 1'b1);
        check("evicted first hit", hit, 1'b0);
        do_walk("refetch", 16'hF020, 16'hC050, 1, 1'b0);
        check("refetch hit", hit, 1'b1);
        @(negedge clk); req(1, 16'h0C00, 0, 0); #1;
        check("ninth hit", hit, 1'b1);
        check("ninth paddr0", paddr0, 16'h2C00);
        @(negedge clk); req(1, 16'h0900, 0, 0); #1;
        check("third page hit", hit, 1'b1);
        check("third page paddr0", paddr0, 16'h2900);

        // Flush mid-walk, refill still lands
        @(negedge clk); req(1, 16'h0F00, 0, 0); #1;
        check("fmw miss stall", stall, 1'b1);
        @(negedge clk); flush = 1'b1; #1;
        check("fmw pet_arb", pet_arb, 1'b1);
        @(negedge clk); flush = 1'b0; ready_arb = 1'b1; rdata_arb = 16'hC01E;
        @(negedge clk); ready_arb = 1'b0; #1;
        check("fmw hit", hit, 1'b1);
        check("fmw paddr0", paddr0, 16'h0F00);
        @(negedge clk); req(1, 16'h0C00, 0, 0); #1;
        check("fmw others flushed stall", stall, 1'b1);
        check("fmw others flushed hit", hit, 1'b0);

        // Reset during that walk
        @(negedge clk); #1;
        check("rmw pet_arb", pet_arb, 1'b1);
        check("rmw addr_arb", addr_arb, 16'hF030);
        reset = 1'b1; req(0, 16'h0000, 0, 0);
        @(negedge clk); #1;
        check("rmw pet_arb drop", pet_arb, 1'b0);
        check("rmw stall drop", stall, 1'b0);
        reset = 1'b0;
        @(negedge clk); req(1, 16'h0F00, 0, 0); #1;
        check("rmw cached lost stall", stall, 1'b1);
        check("rmw cached lost hit", hit, 1'b0);
        req(0, 16'h0000, 0, 0); reset = 1'b1;
        @(negedge clk); reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
